// File: rtl/timer_down60_pkg.sv
// Shared definitions for the timer_down60 countdown timer: state encoding,
// BCD digit limits and the load-time digit clamp.
// Pure package, no logic or timing of its own.
package timer_down60_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

  // Out-of-range preset digits saturate at the digit's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/timer_down60_bcd_down_digit.sv
// One BCD down-counting digit with load, borrow-in enable and borrow-out.
// Load/decrement take effect on the same clock edge; q is a flop output.
// No flow control: enable is a single-cycle strobe from the digit below.
module bcd_down_digit
  import timer_down60_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  output logic [3:0] q,
  output logic       bo
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load wins, otherwise decrement with wrap to MAX.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign bo = en && (q_q == 4'd0);

endmodule

// File: rtl/timer_down60.sv
// MM:SS BCD countdown timer with load/start/stop control and expire pulse.
// Load/decrement on the same edge as the strobe; Bo registered one cycle.
// No backpressure; TIMER_AUTORELOAD_EN enables reload of the last preset.
module timer_down60
  import timer_down60_pkg::*;
#(
  parameter int TICK_EN_DEFAULT = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] D_min,
  input  logic [7:0] D_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] Q_min,
  output logic [7:0] Q_sec,
  output logic       running,
  output logic       done,
  output logic       Bo
);

  state_e      state_q, state_d;
  logic        bo_q, bo_d;
  logic        ld_en;
  logic        dec_en;
  logic [15:0] ld_cnt;
  logic [15:0] preset_c;
  logic        tick_ok;
  logic        is_zero;
  logic        at_one;
  logic        bo_su, bo_st, bo_mu, bo_mt;

  assign preset_c = {clamp_digit(D_min[7:4], MIN_TENS_MAX),
                     clamp_digit(D_min[3:0], UNITS_MAX),
                     clamp_digit(D_sec[7:4], SEC_TENS_MAX),
                     clamp_digit(D_sec[3:0], UNITS_MAX)};

  assign tick_ok = tick && (TICK_EN_DEFAULT != 0);
  assign is_zero = ({Q_min, Q_sec} == 16'h0000);
  assign at_one  = ({Q_min, Q_sec} == 16'h0001);

`ifdef TIMER_AUTORELOAD_EN
  logic [15:0] keep_q, keep_d;

  // Remember the most recent clamped preset for reload on expiry.
  always_comb begin
    keep_d = keep_q;
    if (load) keep_d = preset_c;
  end

  // Reload value register.
  always_ff @(posedge clk) begin
    if (clr) keep_q <= 16'h0000;
    else     keep_q <= keep_d;
  end
`endif

  // Control: load > stop > start > tick, one action per edge.
  always_comb begin
    state_d = state_q;
    bo_d    = 1'b0;
    ld_en   = 1'b0;
    dec_en  = 1'b0;
    ld_cnt  = preset_c;
    if (load) begin
      ld_en   = 1'b1;
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSE) && !is_zero) state_d = RUN;
    end else if (tick_ok && state_q == RUN) begin
      if (at_one) begin
        bo_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
        ld_en   = 1'b1;
        ld_cnt  = keep_q;
        state_d = (keep_q == 16'h0000) ? DONE : RUN;
`else
        dec_en  = 1'b1;
        state_d = DONE;
`endif
      end else begin
        dec_en = 1'b1;
      end
    end
  end

  // State and expire-pulse registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bo_q    <= bo_d;
    end
  end

  bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clk(clk), .clr(clr), .ld(ld_en), .ld_val(ld_cnt[3:0]),
    .en(dec_en), .q(Q_sec[3:0]), .bo(bo_su)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .clr(clr), .ld(ld_en), .ld_val(ld_cnt[7:4]),
    .en(bo_su), .q(Q_sec[7:4]), .bo(bo_st)
  );

  bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
    .clk(clk), .clr(clr), .ld(ld_en), .ld_val(ld_cnt[11:8]),
    .en(bo_st), .q(Q_min[3:0]), .bo(bo_mu)
  );

  // Never borrowed from at 00:00: RUN is never entered with a zero count.
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .clr(clr), .ld(ld_en), .ld_val(ld_cnt[15:12]),
    .en(bo_mu), .q(Q_min[7:4]), .bo(bo_mt)
  );

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign Bo      = bo_q;

  logic unused_ok;
  assign unused_ok = bo_mt;

endmodule

// File: tb/tb_timer_down60.sv
module tb_timer_down60;

  logic       clk = 1'b0;
  logic       clr, tick, load, start, stop;
  logic [7:0] D_min, D_sec;
  logic [7:0] Q_min, Q_sec;
  logic       running, done, Bo;

  always #5 clk = ~clk;

  timer_down60 dut (
    .clk(clk), .clr(clr), .tick(tick), .load(load),
    .D_min(D_min), .D_sec(D_sec), .start(start), .stop(stop),
    .Q_min(Q_min), .Q_sec(Q_sec), .running(running), .done(done), .Bo(Bo)
  );

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] s;
    logic       r;
    logic       d;
    logic       b;
  } exp_t;

  typedef struct {
    logic       clr, load, start, stop, tick;
    logic [7:0] dmin, dsec;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic c, input logic l, input logic [7:0] dm,
                              input logic [7:0] ds, input logic st, input logic sp,
                              input logic tk, input logic [7:0] em, input logic [7:0] es,
                              input logic r, input logic d, input logic b);
    vec_t v;
    v.clr = c; v.load = l; v.dmin = dm; v.dsec = ds;
    v.start = st; v.stop = sp; v.tick = tk;
    v.e.m = em; v.e.s = es; v.e.r = r; v.e.d = d; v.e.b = b;
    return v;
  endfunction

  // Drive one cycle of stimulus, push its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name, input int idx);
    exp_t want, got;
    @(negedge clk);
    clr = v.clr; load = v.load; D_min = v.dmin; D_sec = v.dsec;
    start = v.start; stop = v.stop; tick = v.tick;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    got = {Q_min, Q_sec, running, done, Bo};
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s[%0d]: scoreboard empty, got %h", name, idx, got);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h:%h run=%b done=%b bo=%b, want %h:%h run=%b done=%b bo=%b",
                 name, idx, got.m, got.s, got.r, got.d, got.b,
                 want.m, want.s, want.r, want.d, want.b);
      end
    end
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [15:0] bcd;
    clr = 1'b1; tick = 0; load = 0; start = 0; stop = 0; D_min = 0; D_sec = 0;

    //                 clr ld dmin   dsec   st sp tk  Qmin   Qsec  run done bo
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0));
    // 01:00 -> 00:59
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h59, 1, 0, 0));
`ifndef TIMER_AUTORELOAD_EN
    // 00:02 expires, then DONE ignores tick/start
    tbl.push_back(mk(0, 1, 8'h00, 8'h02, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0));
`else
    // 00:03 expires and reloads, staying in RUN
    tbl.push_back(mk(0, 1, 8'h00, 8'h03, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h03, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h03, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0));
`endif
    // 10:00 -> 09:59 (load clears done), then 00:00 start ignored
    tbl.push_back(mk(0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h59, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    // pause at 00:30, ticks frozen, resume
    tbl.push_back(mk(0, 1, 8'h00, 8'h30, 0, 0, 0, 8'h00, 8'h30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h30, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h29, 1, 0, 0));
    // load mid-RUN with tick and start -> IDLE with new count
    tbl.push_back(mk(0, 1, 8'h02, 8'h00, 1, 0, 1, 8'h02, 8'h00, 0, 0, 0));
    // clamp: FA:7C -> 59:59, run, then clr mid-RUN with tick high
    tbl.push_back(mk(0, 1, 8'hFA, 8'h7C, 0, 0, 0, 8'h59, 8'h59, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h59, 8'h59, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h59, 8'h58, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0));
    // start+tick in IDLE only enters RUN; next tick decrements
    tbl.push_back(mk(0, 1, 8'h00, 8'h10, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h09, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "vec", i);

    // Full minute countdown checked against an integer-seconds model.
    v = mk(0, 1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0, 0, 0);
    step(v, "min_load", 0);
    v = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0);
    step(v, "min_start", 0);
    for (int k = 1; k <= 60; k++) begin
      bcd = to_bcd(60 - k);
`ifdef TIMER_AUTORELOAD_EN
      if (k == 60) bcd = 16'h0100;
      v = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, bcd[15:8], bcd[7:0], 1'b1, 1'b0, k == 60);
`else
      v = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, bcd[15:8], bcd[7:0], k != 60, k == 60, k == 60);
`endif
      step(v, "min_tick", k);
    end
`ifdef TIMER_AUTORELOAD_EN
    v = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);
`else
    v = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
`endif
    step(v, "min_after", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_down60.md
TIMER_DOWN60 -- requirements
Module: timer_down60

Interface
REQ-001 The block SHALL have parameter TICK_EN_DEFAULT, default 1: tick input is honoured; 0 = tick ignored, test builds only.
REQ-002 The block SHALL have port clk  in  1  single rising-edge clock.
REQ-003 The block SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port tick  in  1  one-cycle count strobe (1 Hz enable).
REQ-005 The block SHALL have port load  in  1  load D_min/D_sec into the count.
REQ-006 The block SHALL have port D_min  in  8  BCD minutes preset (tens[7:4], units[3:0]).
REQ-007 The block SHALL have port D_sec  in  8  BCD seconds preset (tens[7:4], units[3:0]).
REQ-008 The block SHALL have port start  in  1  begin or resume counting.
REQ-009 The block SHALL have port stop  in  1  pause counting.
REQ-010 The block SHALL have port Q_min  out  8  current BCD minutes.
REQ-011 The block SHALL have port Q_sec  out  8  current BCD seconds.
REQ-012 The block SHALL have port running  out  1  high in RUN state.
REQ-013 The block SHALL have port done  out  1  level, high in DONE state.
REQ-014 The block SHALL have port Bo  out  1  one-cycle expire pulse, registered, on the edge the count reaches 00:00.

Function
REQ-015 The block SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-016 Priority SHALL be load > stop > start > tick.
REQ-017 Load, in any state, SHALL update the count on the same edge, go to IDLE and clear done.
REQ-018 On load, an invalid digit SHALL be clamped: units >9 to 9, seconds tens >5 to 5, minutes tens >5 to 5.
REQ-019 Start in IDLE or PAUSE with a nonzero count SHALL go to RUN; start with count 00:00 SHALL be ignored.
REQ-020 Stop in RUN SHALL go to PAUSE with the count frozen; stop in any other state SHALL be ignored.
REQ-021 A tick in RUN SHALL decrement the count by one second on the same edge; ticks in other states SHALL be ignored.
REQ-022 Borrow chain: seconds units 0 -> 9 borrows seconds tens; seconds tens 0 -> 5 borrows minutes units; minutes units 0 -> 9 borrows minutes tens; minutes tens never underflows.
REQ-023 A tick that produces 00:00 SHALL set Bo high for exactly one cycle and go to DONE.
REQ-024 Start and tick in DONE SHALL be ignored; the count SHALL hold at 00:00.
REQ-025 Tick and start asserted together in IDLE SHALL only enter RUN; the first decrement occurs on the next tick.
REQ-026 Outputs SHALL be registered only, with no combinational path from inputs.

Reset
REQ-027 When clr is high at a clock edge, the block SHALL set Q_min=00, Q_sec=00, IDLE, running=0, done=0 and Bo=0, overriding all inputs, including mid-count.

Configuration
REQ-028 With TIMER_AUTORELOAD_EN defined, the block SHALL keep the last loaded (clamped) value, and on reaching 00:00 SHALL pulse Bo, reload the kept value and remain in RUN, never entering DONE unless the kept value is 00:00.
REQ-029 With TIMER_AUTORELOAD_EN undefined, the block SHALL have no reload register and behave per REQ-023.

Structure
REQ-030 A shared package SHALL hold the state encoding (2-bit: IDLE=0, RUN=1, PAUSE=2, DONE=3) and the constants SEC_TENS_MAX=5, MIN_TENS_MAX=5 and UNITS_MAX=9.
REQ-031 One sub-module, bcd_down_digit, SHALL be used: one BCD digit with max-value parameter, load, borrow-in enable, borrow-out (digit==0 & enable) and wrap to max; it is instantiated four times.

Verification
REQ-032 Bench: load 01:00, start, 1 tick -> 00:59, Bo=0.
REQ-033 Bench: load 00:02, start, 2 ticks -> 00:00, Bo high one cycle, done=1, further ticks keep 00:00.
REQ-034 Bench: load 10:00, start, tick -> 09:59; load 00:00, then start -> stays IDLE, running=0.
REQ-035 Bench: RUN at 00:30, stop, 5 ticks -> 00:30 PAUSE; start, tick -> 00:29.
REQ-036 Bench: load D_sec=0x7C -> Q_sec=0x59; clr mid-RUN with tick high -> 00:00 IDLE.
REQ-037 Bench: with TIMER_AUTORELOAD_EN, load 00:03, start, 3 ticks -> Bo pulse, Q=00:03, running=1.
